exec_unit: RTL and testbench

- EXEC stage of the multi-cycle core. Sits directly downstream of the decode stage.
- Consumes the registered decode controls (alu_ctl, imm, branch/ALU select flags), the register-file read data and the current PC.
- Produces the ALU/writeback result, the branch decision and the branch target for the MEM/WRITE stages and the PC update.
- Shifts use an iterative 1-bit-per-cycle shifter. All other operations complete in one cycle. Completion is signalled with exec_done.

---
 rtl/exec_unit_if.sv | 34 +++
 rtl/exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_exec_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_if.sv
// Bundle of decode controls, operands and results exchanged between the core
// controller (master) and the EXEC stage (slave).
interface exec_unit_if #(
   parameter int XLEN = 32
) ();
   logic [2:0]      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [4:0]      alu_ctl;
   logic            alu_pc;
   logic            alu_src;
   logic            branch_c;
   logic            branch_uc;
   logic            branch_relative;
   logic [XLEN-1:0] alu_result;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            exec_done;
   logic            busy;

   modport master (
      output state, pc, rs1_data, rs2_data, imm, alu_ctl, alu_pc, alu_src,
             branch_c, branch_uc, branch_relative,
      input  alu_result, branch_taken, branch_target, exec_done, busy
   );

   modport slave (
      input  state, pc, rs1_data, rs2_data, imm, alu_ctl, alu_pc, alu_src,
             branch_c, branch_uc, branch_relative,
      output alu_result, branch_taken, branch_target, exec_done, busy
   );
endinterface

// File: rtl/exec_unit.sv
// EXEC stage: single-cycle ALU, compare and branch resolution, with an
// iterative 1-bit-per-cycle shifter for sll/srl/sra.
module exec_unit #(
   parameter logic [2:0] EXEC_STATE = 3'd2,
   parameter int         XLEN       = 32
) (
   input logic        clk,
   input logic        rst,
   exec_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      HOLD
   } exec_state_t;

   localparam logic [4:0] OP_AND  = 5'd0;
   localparam logic [4:0] OP_OR   = 5'd1;
   localparam logic [4:0] OP_ADD  = 5'd2;
   localparam logic [4:0] OP_XOR  = 5'd3;
   localparam logic [4:0] OP_SLL  = 5'd4;
   localparam logic [4:0] OP_SRL  = 5'd5;
   localparam logic [4:0] OP_SUB  = 5'd6;
   localparam logic [4:0] OP_LT   = 5'd7;
   localparam logic [4:0] OP_GE   = 5'd8;
   localparam logic [4:0] OP_PASS = 5'd10;
   localparam logic [4:0] OP_EQ   = 5'd11;
   localparam logic [4:0] OP_NE   = 5'd12;
   localparam logic [4:0] OP_LTU  = 5'd13;
   localparam logic [4:0] OP_GEU  = 5'd14;
   localparam logic [4:0] OP_SRA  = 5'd15;

   exec_state_t     fsm;
   logic [XLEN-1:0] acc_q;
   logic [4:0]      op_q;
   logic [4:0]      count_q;
   logic            uc_q;
   logic [XLEN-1:0] link_q;
   logic            taken_q;
   logic [XLEN-1:0] target_q;

   logic [XLEN-1:0] alu_result_q;
   logic            branch_taken_q;
   logic [XLEN-1:0] branch_target_q;
   logic            exec_done_q;
   logic            busy_q;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            cmp_bit;
   logic [XLEN-1:0] alu_c;
   logic [XLEN-1:0] result_c;
   logic [XLEN-1:0] link_c;
   logic [XLEN-1:0] target_c;
   logic            taken_c;
   logic            is_shift;
   logic [XLEN-1:0] shifted;

   assign op_a = bus.alu_pc  ? bus.pc  : bus.rs1_data;
   assign op_b = bus.alu_src ? bus.imm : bus.rs2_data;

   // Compare result feeds both the ALU output (bit 0) and the branch decision.
   always_comb begin
      cmp_bit = 1'b0;
      case (bus.alu_ctl)
         OP_LT:   cmp_bit = $signed(op_a) <  $signed(op_b);
         OP_GE:   cmp_bit = $signed(op_a) >= $signed(op_b);
         OP_EQ:   cmp_bit = op_a == op_b;
         OP_NE:   cmp_bit = op_a != op_b;
         OP_LTU:  cmp_bit = op_a <  op_b;
         OP_GEU:  cmp_bit = op_a >= op_b;
         default: cmp_bit = 1'b0;
      endcase
   end

   // Shift ops only reach this path with a zero shift amount, so they pass A.
   always_comb begin
      alu_c = '0;
      case (bus.alu_ctl)
         OP_AND:  alu_c = op_a & op_b;
         OP_OR:   alu_c = op_a | op_b;
         OP_ADD:  alu_c = op_a + op_b;
         OP_XOR:  alu_c = op_a ^ op_b;
         OP_SUB:  alu_c = op_a - op_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  alu_c = op_a;
         OP_PASS: alu_c = op_b;
         OP_LT,
         OP_GE,
         OP_EQ,
         OP_NE,
         OP_LTU,
         OP_GEU:  alu_c = XLEN'(cmp_bit);
         default: alu_c = '0;
      endcase
   end

   assign is_shift = (bus.alu_ctl == OP_SLL) || (bus.alu_ctl == OP_SRL) ||
                     (bus.alu_ctl == OP_SRA);
   assign link_c   = bus.pc + XLEN'(4);
   assign target_c = bus.branch_relative ? (bus.pc + bus.imm)
                                         : ((bus.rs1_data + bus.imm) & ~XLEN'(1));
   assign taken_c  = bus.branch_uc | (bus.branch_c & cmp_bit);
   assign result_c = bus.branch_uc ? link_c : alu_c;

   always_comb begin
      shifted = acc_q;
      case (op_q)
         OP_SLL:  shifted = {acc_q[XLEN-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, acc_q[XLEN-1:1]};
         OP_SRA:  shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: shifted = acc_q;
      endcase
   end

   // Branch info is parked in *_q during a shift so the visible outputs only
   // change on the cycle exec_done is raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm             <= IDLE;
         acc_q           <= '0;
         op_q            <= '0;
         count_q         <= '0;
         uc_q            <= 1'b0;
         link_q          <= '0;
         taken_q         <= 1'b0;
         target_q        <= '0;
         alu_result_q    <= '0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
         exec_done_q     <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         exec_done_q <= 1'b0;
         case (fsm)
            IDLE: begin
               if (bus.state == EXEC_STATE) begin
                  acc_q    <= op_a;
                  op_q     <= bus.alu_ctl;
                  uc_q     <= bus.branch_uc;
                  link_q   <= link_c;
                  taken_q  <= taken_c;
                  target_q <= target_c;
                  if (is_shift && (op_b[4:0] != 5'd0)) begin
                     count_q <= op_b[4:0];
                     busy_q  <= 1'b1;
                     fsm     <= BUSY;
                  end else begin
                     alu_result_q    <= result_c;
                     branch_taken_q  <= taken_c;
                     branch_target_q <= target_c;
                     exec_done_q     <= 1'b1;
                     fsm             <= DONE;
                  end
               end
            end
            BUSY: begin
               acc_q   <= shifted;
               count_q <= count_q - 5'd1;
               if (count_q == 5'd1) begin
                  alu_result_q    <= uc_q ? link_q : shifted;
                  branch_taken_q  <= taken_q;
                  branch_target_q <= target_q;
                  exec_done_q     <= 1'b1;
                  busy_q          <= 1'b0;
                  fsm             <= DONE;
               end
            end
            DONE: fsm <= HOLD;
            HOLD: begin
               if (bus.state != EXEC_STATE) begin
                  fsm <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign bus.alu_result    = alu_result_q;
   assign bus.branch_taken  = branch_taken_q;
   assign bus.branch_target = branch_target_q;
   assign bus.exec_done     = exec_done_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit: a vector table of single operations plus
// hand-written hold/retrigger and reset-during-shift sequences.
module tb_exec_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  ctl;
      logic        apc;
      logic        asrc;
      logic        bc;
      logic        buc;
      logic        brel;
      logic [31:0] exp_res;
      logic        exp_taken;
      logic [31:0] exp_tgt;
      int          exp_lat;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs[20];
   int   n_vecs;

   exec_unit_if #(.XLEN(32)) bus ();

   exec_unit #(
      .EXEC_STATE(3'd2),
      .XLEN      (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Returns to IDLE, triggers the op, then scrambles inputs after capture and
   // waits (bounded) for exec_done, reporting latency and busy cycles seen.
   task automatic applyStimulus(input vec_t v, output int lat, output int busy_cnt);
      bit done;
      bus.state = 3'd3;
      @(negedge clk);
      @(negedge clk);
      bus.pc              = v.pc;
      bus.rs1_data        = v.rs1;
      bus.rs2_data        = v.rs2;
      bus.imm             = v.imm;
      bus.alu_ctl         = v.ctl;
      bus.alu_pc          = v.apc;
      bus.alu_src         = v.asrc;
      bus.branch_c        = v.bc;
      bus.branch_uc       = v.buc;
      bus.branch_relative = v.brel;
      bus.state           = 3'd2;
      lat      = 0;
      busy_cnt = 0;
      done     = 1'b0;
      while (!done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.exec_done) done = 1'b1;
         if (lat == 1) begin
            bus.state    = 3'd3;
            bus.rs1_data = 32'h5A5A_5A5A;
            bus.rs2_data = 32'h0000_0003;
            bus.imm      = 32'h1234_5679;
            bus.pc       = 32'hCAFE_0000;
            bus.alu_ctl  = 5'd3;
         end
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_result"}, bus.alu_result, 32'h0);
      checkOutput({tag, "_taken"}, {31'h0, bus.branch_taken}, 32'h0);
      checkOutput({tag, "_target"}, bus.branch_target, 32'h0);
      checkOutput({tag, "_done"}, {31'h0, bus.exec_done}, 32'h0);
      checkOutput({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
   endtask

   initial begin
      int lat;
      int bcnt;
      int pulses;
      n_checks = 0;
      n_fail   = 0;

      //           pc            rs1           rs2           imm           ctl  apc  asrc bc  buc brel exp_res       tkn  tgt           lat
      vecs[0]  = '{32'h0,        32'hFFFFFFFF, 32'h0,        32'h1,        5'd2, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h00000000,1'b0,32'h00000000,1};
      vecs[1]  = '{32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,32'hFFFFFFFE,1'b0,32'hFFFFFFFE,1};
      vecs[2]  = '{32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00000001,1'b0,32'hFFFFFFFE,1};
      vecs[3]  = '{32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5'd13,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00000000,1'b0,32'hFFFFFFFE,1};
      vecs[4]  = '{32'h100,      32'hFFFFFFFF, 32'h1,        32'h10,       5'd8, 1'b0,1'b0,1'b1,1'b0,1'b1,32'h00000000,1'b0,32'h00000110,1};
      vecs[5]  = '{32'h0,        32'h80000000, 32'h0,        32'h4,        5'd15,1'b0,1'b1,1'b0,1'b0,1'b0,32'hF8000000,1'b0,32'h80000004,5};
      vecs[6]  = '{32'h0,        32'h80000000, 32'h0,        32'h0,        5'd15,1'b0,1'b1,1'b0,1'b0,1'b0,32'h80000000,1'b0,32'h80000000,1};
      vecs[7]  = '{32'h40,       32'h1003,     32'h0,        32'h4,        5'd2, 1'b0,1'b1,1'b0,1'b1,1'b0,32'h00000044,1'b1,32'h00001006,1};
      vecs[8]  = '{32'h0,        32'hF0000000, 32'h8,        32'h0,        5'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00F00000,1'b0,32'hF0000000,9};
      vecs[9]  = '{32'h200,      32'h5,        32'h5,        32'hFFFFFFF0, 5'd11,1'b0,1'b0,1'b1,1'b0,1'b1,32'h00000001,1'b1,32'h000001F0,1};
      vecs[10] = '{32'h0,        32'h3,        32'h4,        32'h0,        5'd9, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h00000000,1'b0,32'h00000002,1};
      vecs[11] = '{32'h0,        32'h3,        32'h4,        32'h0,        5'd31,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00000000,1'b0,32'h00000002,1};
      vecs[12] = '{32'h80,       32'h1,        32'h1,        32'h8,        5'd12,1'b0,1'b0,1'b1,1'b1,1'b1,32'h00000084,1'b1,32'h00000088,1};
      vecs[13] = '{32'h1000,     32'h0,        32'h0,        32'h20,       5'd2, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h00001020,1'b0,32'h00000020,1};
      vecs[14] = '{32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        5'd10,1'b0,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF,1'b0,32'h00000000,1};
      vecs[15] = '{32'h0,        32'h1,        32'h0,        32'h1F,       5'd4, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h80000000,1'b0,32'h00000020,32};
      vecs[16] = '{32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        5'd14,1'b0,1'b0,1'b0,1'b0,1'b0,32'h00000000,1'b0,32'h00000000,1};
      vecs[17] = '{32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,32'hF000F000,1'b0,32'hF0F0F0F0,1};
      vecs[18] = '{32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,32'hFFF0FFF0,1'b0,32'hF0F0F0F0,1};
      vecs[19] = '{32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0FF00FF0,1'b0,32'hF0F0F0F0,1};
      n_vecs = 20;

      rst                 = 1'b1;
      bus.state           = 3'd0;
      bus.pc              = '0;
      bus.rs1_data        = '0;
      bus.rs2_data        = '0;
      bus.imm             = '0;
      bus.alu_ctl         = '0;
      bus.alu_pc          = 1'b0;
      bus.alu_src         = 1'b0;
      bus.branch_c        = 1'b0;
      bus.branch_uc       = 1'b0;
      bus.branch_relative = 1'b0;
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      rst = 1'b0;

      for (int i = 0; i < n_vecs; i++) begin
         applyStimulus(vecs[i], lat, bcnt);
         checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         checkOutput($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].exp_lat - 1));
         checkOutput($sformatf("v%0d_result", i), bus.alu_result, vecs[i].exp_res);
         checkOutput($sformatf("v%0d_taken", i), {31'h0, bus.branch_taken},
                     {31'h0, vecs[i].exp_taken});
         checkOutput($sformatf("v%0d_target", i), bus.branch_target, vecs[i].exp_tgt);
      end

      // Hold: EXEC held for many cycles gives one pulse; a drop then re-raise retriggers.
      bus.state = 3'd3;
      repeat (2) @(negedge clk);
      bus.rs1_data  = 32'd7;
      bus.rs2_data  = 32'd8;
      bus.alu_ctl   = 5'd2;
      bus.alu_src   = 1'b0;
      bus.alu_pc    = 1'b0;
      bus.branch_c  = 1'b0;
      bus.branch_uc = 1'b0;
      bus.state     = 3'd2;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.exec_done) pulses++;
      end
      checkOutput("hold_single_pulse", 32'(pulses), 32'd1);
      checkOutput("hold_result", bus.alu_result, 32'd15);
      bus.state = 3'd3;
      @(negedge clk);
      bus.rs2_data = 32'd9;
      bus.state    = 3'd2;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.exec_done) pulses++;
      end
      checkOutput("retrigger_pulse", 32'(pulses), 32'd1);
      checkOutput("retrigger_result", bus.alu_result, 32'd16);

      // Reset in the middle of a 20-step sll must abort with no exec_done.
      bus.state = 3'd3;
      repeat (2) @(negedge clk);
      bus.rs1_data  = 32'h0000_0003;
      bus.imm       = 32'd20;
      bus.alu_src   = 1'b1;
      bus.alu_ctl   = 5'd4;
      bus.pc        = 32'h0000_0100;
      bus.branch_uc = 1'b1;
      bus.state     = 3'd2;
      pulses = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) bus.state = 3'd3;
         if (bus.exec_done) pulses++;
      end
      checkOutput("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdleOutputs("midshift_reset");
      repeat (30) begin
         @(negedge clk);
         if (bus.exec_done) pulses++;
      end
      checkOutput("midshift_no_done", 32'(pulses), 32'd0);
      checkOutput("midshift_result_still_zero", bus.alu_result, 32'h0);

      applyStimulus('{32'h0, 32'h0000_0003, 32'h0, 32'd2, 5'd4, 1'b0, 1'b1, 1'b0,
                      1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0000_0004, 3}, lat, bcnt);
      checkOutput("post_reset_latency", 32'(lat), 32'd3);
      checkOutput("post_reset_result", bus.alu_result, 32'h0000_000C);
      checkOutput("post_reset_target", bus.branch_target, 32'h0000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
